// File: rtl/obi_mem_responder.sv
// OBI subordinate backed by a flop-based word memory: byte-enabled writes,
// full-word reads, in-order responses after a fixed latency, bounded outstanding.
module obi_mem_responder #(
    parameter int unsigned NumWords       = 256,
    parameter logic [31:0] BaseAddr       = 32'h1000_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IdxW    = $clog2(NumWords);
    localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(NumWords * 4);

    logic [31:0]     mem_r [NumWords];
    logic            pipe_valid_r [RespLatency];
    logic            pipe_err_r   [RespLatency];
    logic [31:0]     pipe_data_r  [RespLatency];
    logic [2:0]      cnt_r;
    logic [2:0]      cnt_free_s;
    logic            hit_s;
    logic            hs_s;
    logic [IdxW-1:0] idx_s;
    logic            resp_err_s;
    logic [31:0]     resp_data_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int unsigned n = 0; n < 4; n++) begin
            if (lanes[n]) begin
                res[8*n +: 8] = new_word[8*n +: 8];
            end else begin
                res[8*n +: 8] = old_word[8*n +: 8];
            end
        end
        return res;
    endfunction

    assign rvalid_o = pipe_valid_r[RespLatency-1];
    assign err_o    = pipe_err_r[RespLatency-1];
    assign rdata_o  = pipe_data_r[RespLatency-1];

    // Address decode, grant and response payload for the current request.
    always_comb begin
        hit_s       = ({1'b0, addr_i} >= {1'b0, BaseAddr}) && ({1'b0, addr_i} < EndAddr)
                      && (addr_i[1:0] == 2'b00);
        idx_s       = IdxW'((addr_i - BaseAddr) >> 2);
        // A response leaving this cycle frees its slot for a same-cycle grant.
        cnt_free_s  = cnt_r - {2'b00, rvalid_o};
        gnt_o       = (cnt_free_s < 3'(MaxOutstanding));
        hs_s        = req_i && gnt_o;
        resp_err_s  = 1'b0;
        resp_data_s = 32'h0000_0000;
        if (!hit_s) begin
            resp_err_s  = 1'b1;
            resp_data_s = 32'h0000_0000;
        end else if (we_i) begin
            resp_err_s  = 1'b0;
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_err_s  = 1'b0;
            resp_data_s = mem_r[idx_s];
        end
    end

    // Word memory; intentionally not reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (hs_s && we_i && hit_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata_i, be_i);
        end
    end

    // Response shift register; invalid stages carry zero payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RespLatency; i++) begin
                pipe_valid_r[i] <= 1'b0;
                pipe_err_r[i]   <= 1'b0;
                pipe_data_r[i]  <= 32'h0000_0000;
            end
        end else begin
            pipe_valid_r[0] <= hs_s;
            pipe_err_r[0]   <= hs_s & resp_err_s;
            pipe_data_r[0]  <= hs_s ? resp_data_s : 32'h0000_0000;
            for (int unsigned i = 1; i < RespLatency; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
            end
        end
    end

    // Outstanding transaction counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= 3'd0;
        end else if (hs_s && !rvalid_o) begin
            cnt_r <= cnt_r + 3'd1;
        end else if (!hs_s && rvalid_o) begin
            cnt_r <= cnt_r - 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three configurations (L1/M1, L3/M1, L3/M3)
// checked every cycle against a queue-based transaction model.
module tb_obi_mem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic        gnt   [3];
    logic        rvalid[3];
    logic [31:0] rdata [3];
    logic        err   [3];

    logic        gnt_seen [3];
    logic [31:0] mem_m [3][256];
    exp_t        exp_q [3][$];
    logic [32:0] obs_q [3][$];
    int          hs_q  [3][$];
    int          rv_q  [3][$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        obi_mem_responder #(
            .NumWords      (256),
            .BaseAddr      (BASE),
            .RespLatency   (g == 0 ? 1 : 3),
            .MaxOutstanding(g == 2 ? 3 : 1)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .req_i   (req[g]),
            .gnt_o   (gnt[g]),
            .addr_i  (addr[g]),
            .we_i    (we[g]),
            .be_i    (be[g]),
            .wdata_i (wdata[g]),
            .rvalid_o(rvalid[g]),
            .rdata_o (rdata[g]),
            .err_o   (err[g])
        );
    end

    function automatic int lat_f(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int maxo_f(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Model: record handshakes at the clock edge and apply writes.
    always @(posedge clk) begin
        logic [31:0] a;
        logic        hit;
        int          idx;
        exp_t        e;
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (rst_n === 1'b1 && req[k] === 1'b1 && gnt_seen[k] === 1'b1) begin
                a   = addr[k];
                hit = (a >= BASE) && (a < BASE + 32'd1024) && (a[1:0] == 2'b00);
                idx = int'((a - BASE) >> 2);
                e.due  = cyc + lat_f(k) - 1;
                e.err  = !hit;
                e.data = 32'h0;
                if (hit && !we[k]) e.data = mem_m[k][idx];
                if (hit && we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[k][b]) mem_m[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
                end
                exp_q[k].push_back(e);
                hs_q[k].push_back(cyc - 1);
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        for (int k = 0; k < 3; k++) begin
            if (rst_n !== 1'b1) exp_q[k].delete();
            exp_v = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
            e     = '0;
            if (exp_v) e = exp_q[k].pop_front();
            check($sformatf("rvalid%0d", k), {31'b0, rvalid[k]}, {31'b0, exp_v});
            check($sformatf("rdata%0d", k), rdata[k], e.data);
            check($sformatf("err%0d", k), {31'b0, err[k]}, {31'b0, e.err});
            check($sformatf("gnt%0d", k), {31'b0, gnt[k]},
                  {31'b0, (exp_q[k].size() < maxo_f(k))});
            gnt_seen[k] = gnt[k];
            if (rvalid[k] === 1'b1) begin
                obs_q[k].push_back({err[k], rdata[k]});
                rv_q[k].push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        bit done;
        done     = 1'b0;
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        be[k]    = b;
        wdata[k] = d;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk);
            done = (gnt_seen[k] === 1'b1) && (rst_n === 1'b1);
            #2;
        end
        if (!done) check($sformatf("hs_timeout%0d", k), 32'd0, 32'd1);
        req[k] = 1'b0;
    endtask

    task automatic clear_obs(input int k);
        obs_q[k].delete();
        hs_q[k].delete();
        rv_q[k].delete();
    endtask

    initial begin
        logic [32:0] o;
        int          h [4];
        int          r [4];
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; be[k] = 4'h0; wdata[k] = 32'h0;
            gnt_seen[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        check("reset_gnt0", {31'b0, gnt[0]}, 32'd1);
        check("reset_rvalid0", {31'b0, rvalid[0]}, 32'd0);
        rst_n = 1'b1;
        idle(8);
        check("post_reset_quiet", obs_q[0].size() + obs_q[1].size() + obs_q[2].size(), 32'd0);

        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 16; w++) issue(k, 1'b1, BASE + 32'(4 * w), 4'hF, 32'(w));
        idle(5);

        // Back-to-back reads of words 0..7 at L=1, M=1.
        clear_obs(0);
        for (int i = 0; i < 8; i++) issue(0, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0);
        idle(3);
        check("b2b_count", obs_q[0].size(), 32'd8);
        for (int i = 0; i < 8 && obs_q[0].size() > 0; i++) begin
            o = obs_q[0].pop_front();
            check($sformatf("b2b_data%0d", i), o[31:0], 32'(i));
            if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(hs_q[0][i] - hs_q[0][i-1]), 32'd1);
            if (i > 0) check($sformatf("b2b_rv%0d", i), 32'(rv_q[0][i] - rv_q[0][i-1]), 32'd1);
        end

        // Byte-enable merge.
        clear_obs(0);
        issue(0, 1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF);
        issue(0, 1'b1, 32'h1000_0010, 4'b0010, 32'h0000_1200);
        issue(0, 1'b0, 32'h1000_0010, 4'h0, 32'h0);
        idle(3);
        check("be_count", obs_q[0].size(), 32'd3);
        if (obs_q[0].size() == 3) begin
            o = obs_q[0][2];
            check("be_rdata", o[31:0], 32'hDEAD_12EF);
            check("be_err", {31'b0, o[32]}, 32'd0);
        end

        // Misses: out of range, below base, misaligned.
        clear_obs(0);
        issue(0, 1'b0, 32'h1000_0400, 4'hF, 32'h0);
        issue(0, 1'b1, 32'h0FFF_FFFC, 4'hF, 32'hFFFF_FFFF);
        issue(0, 1'b0, 32'h1000_0002, 4'hF, 32'h0);
        issue(0, 1'b0, BASE, 4'hF, 32'h0);
        idle(3);
        check("err_count", obs_q[0].size(), 32'd4);
        for (int i = 0; i < 3 && obs_q[0].size() > 1; i++) begin
            o = obs_q[0].pop_front();
            check($sformatf("err_flag%0d", i), {31'b0, o[32]}, 32'd1);
            check($sformatf("err_rdata%0d", i), o[31:0], 32'd0);
        end
        if (obs_q[0].size() > 0) begin
            o = obs_q[0].pop_front();
            check("err_word0", o[31:0], 32'd0);
        end

        // Outstanding limit: L=3, M=1 with req held high.
        clear_obs(1);
        for (int i = 0; i < 4; i++) issue(1, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0);
        idle(4);
        check("lim_count", rv_q[1].size(), 32'd4);
        if (rv_q[1].size() == 4 && hs_q[1].size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                h[i] = hs_q[1][i];
                r[i] = rv_q[1][i];
                o    = obs_q[1][i];
                check($sformatf("lim_lat%0d", i), 32'(r[i] - h[i]), 32'd3);
                check($sformatf("lim_data%0d", i), o[31:0], 32'(i));
                if (i > 0) check($sformatf("lim_gap%0d", i), 32'(h[i] - h[i-1]), 32'd3);
            end
        end

        // Reset with two reads in flight at L=3, M=3.
        clear_obs(2);
        issue(2, 1'b0, BASE + 32'd20, 4'h0, 32'h0);
        issue(2, 1'b0, BASE + 32'd24, 4'h0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(8);
        check("mid_rst_quiet", obs_q[2].size(), 32'd0);
        clear_obs(2);
        issue(2, 1'b0, BASE + 32'd28, 4'h0, 32'h0);
        idle(4);
        check("mid_rst_count", obs_q[2].size(), 32'd1);
        if (obs_q[2].size() == 1 && hs_q[2].size() == 1) begin
            o = obs_q[2][0];
            check("mid_rst_data", o[31:0], 32'd7);
            check("mid_rst_lat", 32'(rv_q[2][0] - hs_q[2][0]), 32'd3);
        end

        // Randomized traffic on all configurations, with one reset pulse.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 60; t++) begin
                int          sel;
                logic [31:0] a;
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                else if (sel == 1) a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'd1024;
                else               a = BASE + 32'(4 * $urandom_range(0, 15));
                issue(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                if (k == 1 && t == 30) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    #2;
                    rst_n = 1'b1;
                end
            end
            idle(5);
        end

        idle(5);
        for (int k = 0; k < 3; k++)
            check($sformatf("drained%0d", k), exp_q[k].size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/obi_mem_responder.md
# obi_mem_responder

OBI subordinate (responder) that serves the core's instruction or data request port from an internal flop-based word memory. It accepts `req`/`gnt` handshakes, performs byte-enabled writes and reads, and returns in-order `rvalid` responses a fixed number of cycles after each grant. The number of outstanding transactions is bounded. It is the memory-side end of the core's fetch/LSU interface and is used as a local memory and as a bench responder.

## Interface

- `NumWords`, default 256: memory depth in 32-bit words; must be a power of two, ≥ 4.
- `BaseAddr`, default 32'h1000_0000: byte address of word 0; aligned to `NumWords*4`.
- `RespLatency`, default 1: cycles from handshake to `rvalid_o`; range 1..4.
- `MaxOutstanding`, default 1: maximum granted-but-unanswered transactions; range 1..4. Values above `RespLatency` have no additional effect.
- `clk_i` in 1: clock. Single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 1: request valid.
- `gnt_o` out 1: request granted. The handshake completes when `req_i & gnt_o` is high at a rising edge.
- `addr_i` in 32: byte address.
- `we_i` in 1: 1 = write, 0 = read.
- `be_i` in 4: byte enables. Bit n selects `wdata_i[8n+7:8n]`.
- `wdata_i` in 32: write data.
- `rvalid_o` out 1: response valid, high for exactly one cycle per transaction.
- `rdata_o` out 32: read data. Valid only with `rvalid_o`; otherwise 0.
- `err_o` out 1: response error. Valid only with `rvalid_o`; otherwise 0.

## Operation

- **Address decode.**
  - The address hits when `addr_i >= BaseAddr`, `addr_i < BaseAddr + NumWords*4`, and `addr_i[1:0] == 0`.
  - Word index is `(addr_i - BaseAddr) >> 2`, truncated to `$clog2(NumWords)` bits.
- **Write with hit.**
  - At the handshake edge, each byte lane with `be_i[n]=1` is updated. Other lanes keep their value.
  - Response: `rdata_o=0`, `err_o=0`.
- **Read with hit.**
  - The word is sampled at the handshake edge, so it reflects all earlier handshakes.
  - `be_i` is ignored. The full word is returned.
- **Miss (out of range or misaligned).**
  - Memory is not modified.
  - Response: `err_o=1`, `rdata_o=0`.
- **`be_i == 0` write with hit.** No lane changes; response is `err_o=0`.
- **Response pipeline.**
  - A shift register of depth `RespLatency` holds `{valid, err, rdata}` per stage.
  - Responses are strictly in handshake order. There is no response backpressure.
- **Outstanding counter.**
  - `cnt` is 0..`MaxOutstanding`. It increments on a handshake and decrements on `rvalid_o`.
  - A handshake and `rvalid_o` in the same cycle leave `cnt` unchanged.
- **Grant.**
  - `gnt_o = (cnt - rvalid_o) < MaxOutstanding`. A response retiring in the current cycle frees its slot for a same-cycle grant.
  - `gnt_o` does not depend on `req_i`.
- **Memory contents** are not reset. Reads of never-written words return X in simulation.

## Timing

- **Reset values:**
  - `rvalid_o=0`, `rdata_o=0`, `err_o=0`.
  - `cnt=0`, so `gnt_o=1`.
  - All pipeline valid bits are 0.
- **Latency.** A handshake at the edge ending cycle t gives `rvalid_o=1` during cycle t+`RespLatency`.
- **Throughput.** With `MaxOutstanding >= RespLatency`, one transaction per cycle is sustained indefinitely.
- **Throttled throughput.** With `MaxOutstanding = M < RespLatency = L`, at most M handshakes occur per L cycles.
- **Read-after-write.** A read handshaken in the cycle after a write to the same word returns the written data. No hazard cycles are inserted.
- **Reset mid-operation.**
  - All in-flight responses are discarded and `cnt` returns to 0.
  - No `rvalid_o` is produced after reset deassertion for pre-reset requests.
  - Memory contents are retained.
- **Request signals.** `addr_i`, `we_i`, `be_i`, `wdata_i` are sampled only at handshake edges. `req_i` may be dropped without a grant.

## Test plan

- **Reset.**
  - Stimulus: assert `rst_ni=0` during traffic.
  - Required: `gnt_o=1`, `rvalid_o=0`, `rdata_o=0`, `err_o=0`.
  - Required: no `rvalid_o` in the 8 cycles after release with `req_i=0`.
- **Byte-enable write and read-back (`RespLatency=1`).**
  - Stimulus: write 32'hDEADBEEF to 32'h1000_0010 with be=4'hF, then write 32'h0000_1200 with be=4'b0010.
  - Stimulus: read 32'h1000_0010 on the next cycle.
  - Required: `rdata_o=32'hDEAD12EF`, `err_o=0`, one cycle after the read handshake.
- **Back-to-back reads.**
  - Stimulus: `RespLatency=1`, `MaxOutstanding=1`, 8 consecutive reads of words 0..7, each pre-written with its index.
  - Required: `gnt_o` stays high, `rvalid_o` is high for 8 consecutive cycles, and `rdata_o` is 0..7 in order.
- **Errors.**
  - Stimulus: read 32'h1000_0400 (`NumWords=256`), write 32'h0FFF_FFFC, and read 32'h1000_0002.
  - Required: each response has `err_o=1` and `rdata_o=0`.
  - Required: a subsequent read of word 0 is unchanged.
- **Outstanding limit.**
  - Stimulus: `RespLatency=3`, `MaxOutstanding=1`, `req_i` held high.
  - Required: handshakes every 3rd cycle; `gnt_o` is low for 2 cycles after each grant; responses arrive 3 cycles after their grants.
- **Reset mid-flight.**
  - Stimulus: `RespLatency=3`, `MaxOutstanding=3`; 2 reads are handshaken, then `rst_ni` is pulsed before either response.
  - Required: no `rvalid_o` after release, `cnt=0`, and a new read returns the correct data after 3 cycles.
